// File: rtl/test_sequencer.sv
// test_sequencer: drives one test program through a CPU under test and grades it.
//   A run is: hold the CPU in reset, count its instruction fetches until it runs
//   off the end of the program (or hits the step limit), then walk the GPR file
//   one register per clock against an expected-value table.
// Ports:
//   clk, rst (async, active-low)  - clock / reset
//   start                         - level in IDLE; rising edge needed to re-run from DONE
//   dut_rst                       - active-high reset to the CPU under test
//   fetch_pulse, instr_valid      - fetch strobe and "word is defined" flag from the CPU
//   rd_addr / rd_data / exp_data  - GPR debug read index, GPR value, expected value
//   step_count                    - valid fetches counted this run (saturating)
//   busy, finish, pass, timeout   - status flags
//   mismatch_count, first_fail    - number of bad registers, lowest bad index
// Optional feature: define SEQ_TIMEOUT_EN to add a RUN-state watchdog that
//   aborts to DONE after TIMEOUT_CYCLES clocks without a fetch.
module test_sequencer #(
  parameter int WIDTH          = 32,
  parameter int NREGS          = 32,
  parameter int MAX_STEPS      = 100,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_rst,
  input  logic             fetch_pulse,
  input  logic             instr_valid,
  output logic [4:0]       rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  input  logic [WIDTH-1:0] exp_data,
  output logic [15:0]      step_count,
  output logic             busy,
  output logic             finish,
  output logic             pass,
  output logic             timeout,
  output logic [5:0]       mismatch_count,
  output logic [4:0]       first_fail
);

  typedef enum logic [2:0] {IDLE, HOLD, RUN, CMP, DONE} state_t;

  state_t      state;
  logic [7:0]  hold_cnt;
  logic        start_q;
  logic [16:0] step_inc;
  logic [15:0] step_sat;
  logic        reg_miss;
  logic [5:0]  mm_inc;
  logic        launch;

  assign step_inc = {1'b0, step_count} + 17'd1;
  assign step_sat = step_inc[16] ? 16'hFFFF : step_inc[15:0];
  assign reg_miss = (rd_data != exp_data);
  assign mm_inc   = mismatch_count + 6'd1;
  // IDLE reacts to the start level; DONE needs a fresh rising edge so a
  // start held high from the previous run does not immediately re-launch.
  assign launch   = ((state == IDLE) && start) ||
                    ((state == DONE) && start && !start_q);

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] wd_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      start_q        <= 1'b0;
      dut_rst        <= 1'b1;
      rd_addr        <= '0;
      step_count     <= '0;
      busy           <= 1'b0;
      finish         <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      first_fail     <= '0;
`ifdef SEQ_TIMEOUT_EN
      timeout        <= 1'b0;
      wd_cnt         <= '0;
`endif
    end else begin
      start_q <= start;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            state          <= HOLD;
            dut_rst        <= 1'b1;
            hold_cnt       <= '0;
            busy           <= 1'b1;
            step_count     <= '0;
            mismatch_count <= '0;
            first_fail     <= '0;
            finish         <= 1'b0;
            pass           <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            timeout        <= 1'b0;
`endif
          end
        end

        HOLD: begin
          // dut_rst was raised on HOLD entry, so it stays high RESET_CYCLES clocks.
          if (hold_cnt == 8'(RESET_CYCLES - 1)) begin
            state   <= RUN;
            dut_rst <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        RUN: begin
          if (fetch_pulse) begin
`ifdef SEQ_TIMEOUT_EN
            wd_cnt <= '0;
`endif
            if (instr_valid) begin
              step_count <= step_sat;
              if (step_sat == 16'(MAX_STEPS))
                state <= CMP;
            end else begin
              // Fetched blank memory: the program has ended.
              state <= CMP;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          else if (wd_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            state   <= DONE;
            timeout <= 1'b1;
            finish  <= 1'b1;
            pass    <= 1'b0;
            busy    <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
`endif
        end

        CMP: begin
          if (reg_miss) begin
            mismatch_count <= mm_inc;
            if (mismatch_count == 6'd0)
              first_fail <= rd_addr;
          end
          if (rd_addr == 5'(NREGS - 1)) begin
            state   <= DONE;
            rd_addr <= '0;
            busy    <= 1'b0;
            finish  <= 1'b1;
            // Include the register compared on this final clock.
            pass    <= ((reg_miss ? mm_inc : mismatch_count) == 6'd0) && !timeout;
          end else begin
            rd_addr <= rd_addr + 5'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_sequencer.sv
module tb_test_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, fetch_pulse, instr_valid;
  logic        dut_rst_a, busy_a, finish_a, pass_a, timeout_a;
  logic        dut_rst_b, busy_b, finish_b, pass_b, timeout_b;
  logic [4:0]  rd_addr_a, rd_addr_b, first_fail_a, first_fail_b;
  logic [15:0] step_count_a, step_count_b;
  logic [5:0]  mismatch_count_a, mismatch_count_b;
  logic [31:0] rd_data_a, exp_data_a, rd_data_b, exp_data_b;
  logic [31:0] regs [32];
  logic [31:0] exp_tab [32];

  assign rd_data_a  = regs[rd_addr_a];
  assign exp_data_a = exp_tab[rd_addr_a];
  assign rd_data_b  = regs[rd_addr_b];
  assign exp_data_b = exp_tab[rd_addr_b];

  // Instance A: default parameters.
  test_sequencer dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_rst(dut_rst_a),
    .fetch_pulse(fetch_pulse), .instr_valid(instr_valid),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .exp_data(exp_data_a),
    .step_count(step_count_a), .busy(busy_a), .finish(finish_a),
    .pass(pass_a), .timeout(timeout_a),
    .mismatch_count(mismatch_count_a), .first_fail(first_fail_a)
  );

  // Instance B: short step limit and longer reset hold.
  test_sequencer #(.MAX_STEPS(5), .RESET_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_rst(dut_rst_b),
    .fetch_pulse(fetch_pulse), .instr_valid(instr_valid),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .exp_data(exp_data_b),
    .step_count(step_count_b), .busy(busy_b), .finish(finish_b),
    .pass(pass_b), .timeout(timeout_b),
    .mismatch_count(mismatch_count_b), .first_fail(first_fail_b)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          nf;     // valid fetches before the blank word
    logic [31:0] mask;   // registers made to differ from the table
    int          st;     // expected step_count
    int          mm;     // expected mismatch_count
    int          ff;     // expected first_fail
    logic        ps;     // expected pass
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Inputs change just after the falling edge; outputs are read there too.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_regs(input logic [31:0] mask);
    for (int i = 0; i < 32; i++) begin
      exp_tab[i] = 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
      regs[i]    = mask[i] ? (exp_tab[i] ^ (32'h1 << i)) : exp_tab[i];
    end
  endtask

  task automatic wait_run_a();
    int n;
    n = 0;
    while (!(busy_a && !dut_rst_a) && n < 20) begin
      step();
      n++;
    end
    chk("a_reached_run", 32'(n < 20), 32'd1);
  endtask

  task automatic wait_finish_a(output int n);
    n = 0;
    while (!finish_a && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic run_a(input int nf, input logic [31:0] mask, output int cmp_clk);
    set_regs(mask);
    start_a = 1'b1;
    step();
    wait_run_a();
    instr_valid = 1'b1;
    for (int k = 0; k < nf; k++) begin
      fetch_pulse = 1'b1;
      step();
      fetch_pulse = 1'b0;
      step();
    end
    fetch_pulse = 1'b1;
    instr_valid = 1'b0;
    step();
    fetch_pulse = 1'b0;
    chk("a_cmp_start_addr", 32'(rd_addr_a), 32'd0);
    wait_finish_a(cmp_clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    fetch_pulse = 1'b0; instr_valid = 1'b0;
    set_regs(32'h0);
    #2 rst = 1'b0;
    #1;
    chk("rst_dut_rst", 32'(dut_rst_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_finish", 32'(finish_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_step", 32'(step_count_a), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr_a), 32'd0);
    step(); step();
    rst = 1'b1;
    step(); step();
    chk("idle_dut_rst", 32'(dut_rst_a), 32'd1);
    chk("idle_busy", 32'(busy_a), 32'd0);

    tbl[0] = '{10, 32'h0000_0000, 10, 0, 0, 1'b1};
    tbl[1] = '{10, 32'h0002_0008, 10, 2, 3, 1'b0};
    tbl[2] = '{0,  32'h0000_0000, 0,  0, 0, 1'b1};
    tbl[3] = '{3,  32'h8000_0000, 3,  1, 31, 1'b0};
    tbl[4] = '{1,  32'h8000_0001, 1,  2, 0, 1'b0};
    tbl[5] = '{7,  32'hFFFF_FFFF, 7, 32, 0, 1'b0};

    for (int v = 0; v < 6; v++) begin
      int cc;
      run_a(tbl[v].nf, tbl[v].mask, cc);
      chk("vec_cmp_clocks", 32'(cc), 32'd32);
      chk("vec_step", 32'(step_count_a), 32'(tbl[v].st));
      chk("vec_mismatch", 32'(mismatch_count_a), 32'(tbl[v].mm));
      chk("vec_first_fail", 32'(first_fail_a), 32'(tbl[v].ff));
      chk("vec_pass", 32'(pass_a), 32'(tbl[v].ps));
      chk("vec_finish", 32'(finish_a), 32'd1);
      chk("vec_busy", 32'(busy_a), 32'd0);
      chk("vec_dut_rst", 32'(dut_rst_a), 32'd0);
      chk("vec_timeout", 32'(timeout_a), 32'd0);
      // start still high and stray fetches in DONE: results must hold.
      instr_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        fetch_pulse = 1'b1;
        step();
      end
      fetch_pulse = 1'b0;
      chk("vec_done_hold_finish", 32'(finish_a), 32'd1);
      chk("vec_done_hold_step", 32'(step_count_a), 32'(tbl[v].st));
      chk("vec_done_hold_busy", 32'(busy_a), 32'd0);
      $display("vec %0d: fetches=%0d step=%0d mm=%0d ff=%0d pass=%0d cmp_clocks=%0d",
               v, tbl[v].nf, step_count_a, mismatch_count_a, first_fail_a, pass_a, cc);
      start_a = 1'b0;
      step();
    end

    // Instance B: 3-clock reset hold with fetches during it, then step limit.
    set_regs(32'h0);
    start_b = 1'b1;
    fetch_pulse = 1'b1;
    instr_valid = 1'b1;
    step();
    n = 0;
    while (busy_b && dut_rst_b && n < 20) begin
      n++;
      step();
    end
    fetch_pulse = 1'b0;
    chk("b_hold_clocks", 32'(n), 32'd3);
    chk("b_hold_step", 32'(step_count_b), 32'd0);
    chk("b_in_run", 32'(busy_b && !dut_rst_b), 32'd1);
    $display("hold: dut_rst high for %0d clocks, step=%0d", n, step_count_b);
    fetch_pulse = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k == 5) begin
        chk("b_limit_step", 32'(step_count_b), 32'd5);
        chk("b_limit_cmp_addr", 32'(rd_addr_b), 32'd0);
      end
    end
    fetch_pulse = 1'b0;
    chk("b_sixth_step", 32'(step_count_b), 32'd5);
    chk("b_sixth_addr", 32'(rd_addr_b), 32'd1);
    n = 0;
    while (!finish_b && n < 100) begin
      step();
      n++;
    end
    chk("b_finish", 32'(finish_b), 32'd1);
    chk("b_final_step", 32'(step_count_b), 32'd5);
    chk("b_pass", 32'(pass_b), 32'd1);
    $display("limit: step=%0d pass=%0d", step_count_b, pass_b);
    start_b = 1'b0;
    step();

    // Reset while comparing register 9.
    set_regs(32'h0);
    start_a = 1'b1;
    step();
    wait_run_a();
    fetch_pulse = 1'b1;
    instr_valid = 1'b0;
    step();
    fetch_pulse = 1'b0;
    n = 0;
    while (rd_addr_a != 5'd9 && n < 50) begin
      step();
      n++;
    end
    chk("mid_reached_addr9", 32'(rd_addr_a), 32'd9);
    rst = 1'b0;
    start_a = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(rd_addr_a), 32'd0);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_dut_rst", 32'(dut_rst_a), 32'd1);
    chk("mid_rst_step", 32'(step_count_a), 32'd0);
    chk("mid_rst_finish", 32'(finish_a), 32'd0);
    chk("mid_rst_mm", 32'(mismatch_count_a), 32'd0);
    step(); step();
    rst = 1'b1;
    step(); step(); step();
    chk("mid_idle_busy", 32'(busy_a), 32'd0);
    chk("mid_idle_dut_rst", 32'(dut_rst_a), 32'd1);
    $display("reset in CMP: rd_addr=%0d dut_rst=%0d busy=%0d", rd_addr_a, dut_rst_a, busy_a);

    // No fetches after reset hold.
    set_regs(32'h0);
    start_a = 1'b1;
    step();
    wait_run_a();
`ifdef SEQ_TIMEOUT_EN
    wait_finish_a(n);
    chk("to_clocks", 32'(n), 32'd64);
    chk("to_timeout", 32'(timeout_a), 32'd1);
    chk("to_finish", 32'(finish_a), 32'd1);
    chk("to_pass", 32'(pass_a), 32'd0);
    chk("to_rd_addr", 32'(rd_addr_a), 32'd0);
    $display("watchdog: timeout after %0d clocks", n);
`else
    repeat (80) step();
    chk("nowd_busy", 32'(busy_a), 32'd1);
    chk("nowd_finish", 32'(finish_a), 32'd0);
    chk("nowd_timeout", 32'(timeout_a), 32'd0);
    fetch_pulse = 1'b1;
    instr_valid = 1'b0;
    step();
    fetch_pulse = 1'b0;
    wait_finish_a(n);
    chk("nowd_late_finish", 32'(finish_a), 32'd1);
    chk("nowd_late_pass", 32'(pass_a), 32'd1);
    $display("no watchdog: still running after 80 idle clocks, then pass=%0d", pass_a);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
